// File: rtl/sdr_cmd_sched.sv
// sdr_cmd_sched: command scheduler in front of the SDR controller core.
// Arbitrates the single SDRAM command path between two requesters (r0, r1)
// and a periodic auto-refresh generator, issues one command at a time over a
// valid/ready/done handshake and routes completion/read data back to the owner.
//
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   rX_req/write/addr/wdata  requester X command (X = 0,1)
//   rX_gnt                one-cycle grant pulse (first ISSUE cycle)
//   rX_done/rX_rdata      one-cycle completion pulse, read data held until next
//   be_valid/op/addr/wdata  command to controller core (op: 00 rd, 01 wr, 10 ref)
//   be_ready/done/rdata   core accept, core completion, core read data
//   ref_pending           postponed refresh count
//   ref_overflow          sticky: a refresh tick was lost while saturated

// Per-requester return path: grant pulse, completion pulse, read data hold.
module sdr_cmd_sched_port #(
  parameter int DW = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          gnt_set,
  input  logic          done_set,
  input  logic [DW-1:0] be_rdata,
  output logic          gnt,
  output logic          done,
  output logic [DW-1:0] rdata
);
  always_ff @(posedge pclk) begin
    if (preset) begin
      gnt   <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      gnt  <= gnt_set;
      done <= done_set;
      if (done_set) rdata <= be_rdata;
    end
  end
endmodule

module sdr_cmd_sched #(
  parameter int REF_INTERVAL = 780,
  parameter int REF_MAX_PEND = 4,
  parameter int AW           = 16,
  parameter int DW           = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          r0_req,
  input  logic          r0_write,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_write,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic          be_valid,
  output logic [1:0]    be_op,
  output logic [AW-1:0] be_addr,
  output logic [DW-1:0] be_wdata,
  input  logic          be_ready,
  input  logic          be_done,
  input  logic [DW-1:0] be_rdata,
  output logic [2:0]    ref_pending,
  output logic          ref_overflow
);
  localparam int             TW   = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [TW-1:0]  TMAX = TW'(REF_INTERVAL - 1);
  localparam logic [2:0]     PMAX = 3'(REF_MAX_PEND);
  localparam logic [1:0]     OP_RD = 2'b00, OP_WR = 2'b01, OP_REF = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tcnt;
  logic              tick;
  logic [2:0]        pend;
  logic              ovf;
  logic              last_r1;   // most recent grant went to r1
  logic              dec_vld, dec_ref, dec_id;
  logic              own_ref, own_id;
  logic [1:0]        op_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [1:0]        req, gnt_set, done_set, gnt, done;
  logic [1:0][DW-1:0] rdata;
  logic              ref_done;
  logic              sel_write;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;

  assign req = {r1_req, r0_req};

  // Refresh timer: wraps at REF_INTERVAL-1, tick on the wrap edge.
  assign tick = (tcnt == TMAX);
  always_ff @(posedge pclk) begin
    if (preset)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // Pending refresh count. Tick and refresh completion together cancel out,
  // so nothing is lost and overflow is only flagged for a genuinely dropped tick.
  always_ff @(posedge pclk) begin
    if (preset) begin
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      unique case ({tick, ref_done})
        2'b10: begin
          if (pend == PMAX) ovf  <= 1'b1;
          else              pend <= pend + 1'b1;
        end
        2'b01:   pend <= pend - 1'b1;
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration and next state. Tie between requesters goes to the one
  // not most recently granted.
  always_comb begin
    state_nxt = state;
    dec_vld   = 1'b0;
    dec_ref   = 1'b0;
    dec_id    = 1'b0;
    gnt_set   = '0;
    done_set  = '0;
    ref_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend == PMAX) begin
          dec_vld = 1'b1;
          dec_ref = 1'b1;
        end else if (|req) begin
          dec_vld = 1'b1;
          dec_id  = req[1] & (~req[0] | ~last_r1);
        end else if (pend != '0) begin
          dec_vld = 1'b1;
          dec_ref = 1'b1;
        end
        if (dec_vld) begin
          state_nxt = ISSUE;
          if (!dec_ref) gnt_set[dec_id] = 1'b1;
        end
      end
      ISSUE: if (be_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (be_done) begin
          state_nxt = IDLE;
          if (own_ref) ref_done         = 1'b1;
          else         done_set[own_id] = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_write = dec_id ? r1_write : r0_write;
  assign sel_addr  = dec_id ? r1_addr  : r0_addr;
  assign sel_wdata = dec_id ? r1_wdata : r0_wdata;

  // Command latch: held stable from decision through completion.
  always_ff @(posedge pclk) begin
    if (preset) begin
      own_ref <= 1'b0;
      own_id  <= 1'b0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      last_r1 <= 1'b1;      // favour r0 first
    end else if (dec_vld) begin
      own_ref <= dec_ref;
      own_id  <= dec_id;
      if (dec_ref) begin
        op_q    <= OP_REF;
        addr_q  <= '0;
        wdata_q <= '0;
      end else begin
        op_q    <= sel_write ? OP_WR : OP_RD;
        addr_q  <= sel_addr;
        wdata_q <= sel_write ? sel_wdata : '0;
        last_r1 <= dec_id;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    sdr_cmd_sched_port #(.DW(DW)) u_port (
      .pclk     (pclk),
      .preset   (preset),
      .gnt_set  (gnt_set[i]),
      .done_set (done_set[i]),
      .be_rdata (be_rdata),
      .gnt      (gnt[i]),
      .done     (done[i]),
      .rdata    (rdata[i])
    );
  end

  assign r0_gnt       = gnt[0];
  assign r1_gnt       = gnt[1];
  assign r0_done      = done[0];
  assign r1_done      = done[1];
  assign r0_rdata     = rdata[0];
  assign r1_rdata     = rdata[1];
  assign be_valid     = (state == ISSUE);
  assign be_op        = op_q;
  assign be_addr      = addr_q;
  assign be_wdata     = wdata_q;
  assign ref_pending  = pend;
  assign ref_overflow = ovf;
endmodule

// File: tb/tb_sdr_cmd_sched.sv
module tb_sdr_cmd_sched;
  localparam int RI = 16;
  localparam int RM = 4;

  localparam int M_RST = 0, M_RAND = 1, M_WR = 2, M_RR = 3, M_DEFER = 4,
                 M_STALL = 5, M_COINC = 6;

  logic        pclk, preset;
  logic        r0_req, r0_write, r1_req, r1_write;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_done, r1_gnt, r1_done;
  logic [15:0] r0_rdata, r1_rdata;
  logic        be_valid, be_ready, be_done;
  logic [1:0]  be_op;
  logic [15:0] be_addr, be_wdata, be_rdata;
  logic [2:0]  ref_pending;
  logic        ref_overflow;

  sdr_cmd_sched #(.REF_INTERVAL(RI), .REF_MAX_PEND(RM), .AW(16), .DW(16)) dut (
    .pclk(pclk), .preset(preset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
    .be_valid(be_valid), .be_op(be_op), .be_addr(be_addr), .be_wdata(be_wdata),
    .be_ready(be_ready), .be_done(be_done), .be_rdata(be_rdata),
    .ref_pending(ref_pending), .ref_overflow(ref_overflow)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int mode   = M_RST;
  int cyc    = 0;
  int gcyc   = 0;

  // Reference model: an in-flight command record plus refresh bookkeeping.
  int          m_tcount, m_pend, m_last, m_own, wcnt;
  bit          m_ovf, m_busy, m_acc;
  logic [1:0]  m_op;
  logic [15:0] m_addr, m_wdata;
  logic [1:0]  exp_gnt, exp_done;
  logic [15:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic start_ref();
    m_busy = 1; m_acc = 0; m_own = 2;
    m_op = 2'b10; m_addr = '0; m_wdata = '0;
  endtask

  task automatic start_req(input int id);
    logic w;
    w = id ? r1_write : r0_write;
    m_busy = 1; m_acc = 0; m_own = id; m_last = id;
    exp_gnt[id] = 1'b1;
    m_op    = w ? 2'b01 : 2'b00;
    m_addr  = id ? r1_addr : r0_addr;
    m_wdata = w ? (id ? r1_wdata : r0_wdata) : 16'h0;
  endtask

  task automatic model_step();
    int  n;
    bit  tick, rc, pick1;
    if (preset) begin
      m_tcount = 0; m_pend = 0; m_ovf = 0; m_last = 1; m_busy = 0; m_acc = 0;
      m_own = 0; m_op = '0; m_addr = '0; m_wdata = '0; wcnt = 0;
      exp_gnt = '0; exp_done = '0; exp_rd[0] = '0; exp_rd[1] = '0;
      return;
    end
    tick = (m_tcount == RI - 1);
    m_tcount = tick ? 0 : m_tcount + 1;
    exp_gnt = '0; exp_done = '0; rc = 0;
    if (!m_busy) begin
      if (m_pend == RM) start_ref();
      else if (r0_req || r1_req) begin
        pick1 = r1_req && (!r0_req || m_last == 0);
        start_req(pick1 ? 1 : 0);
      end else if (m_pend > 0) start_ref();
    end else if (!m_acc) begin
      if (be_ready) begin m_acc = 1; wcnt = 0; end
    end else if (be_done) begin
      m_busy = 0;
      if (m_own == 2) rc = 1;
      else begin
        exp_done[m_own] = 1'b1;
        exp_rd[m_own]   = be_rdata;
      end
    end else wcnt++;
    n = m_pend + int'(tick) - int'(rc);
    if (n > RM) begin n = RM; m_ovf = 1; end
    m_pend = n;
  endtask

  task automatic gen_inputs();
    bit wt_done;
    wt_done  = m_busy && m_acc && (wcnt >= 1);
    preset   = 1'b0;
    r0_write = 1'($urandom_range(0, 1));
    r1_write = 1'($urandom_range(0, 1));
    r0_addr  = 16'($urandom); r1_addr  = 16'($urandom);
    r0_wdata = 16'($urandom); r1_wdata = 16'($urandom);
    be_rdata = 16'($urandom);
    r0_req   = 1'($urandom_range(0, 1));
    r1_req   = 1'($urandom_range(0, 1));
    be_ready = ($urandom_range(0, 3) != 0);
    be_done  = ($urandom_range(0, 2) == 0);
    case (mode)
      M_RST: begin preset = 1'b1; r0_req = 1'b1; end
      M_WR: begin
        r0_req = 1'b1; r0_write = 1'b1; r0_addr = 16'h0123; r0_wdata = 16'hBEEF;
        r1_req = 1'b0; be_ready = 1'b1; be_done = wt_done;
      end
      M_RR: begin
        r0_req = 1'b1; r1_req = 1'b1; r0_write = 1'b0; r1_write = 1'b0;
        be_ready = 1'b1; be_done = wt_done; be_rdata = 16'h5A5A;
      end
      M_DEFER: begin r0_req = 1'b1; r1_req = 1'b0; be_ready = 1'b1; be_done = wt_done; end
      M_STALL: be_ready = 1'b0;
      M_COINC: begin
        r0_req = 1'b0; r1_req = 1'b0; be_ready = 1'b1;
        be_done = m_busy && m_acc && (m_tcount == RI - 1);
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("r0_gnt",  32'(r0_gnt),  32'(exp_gnt[0]));
    chk("r1_gnt",  32'(r1_gnt),  32'(exp_gnt[1]));
    chk("r0_done", 32'(r0_done), 32'(exp_done[0]));
    chk("r1_done", 32'(r1_done), 32'(exp_done[1]));
    chk("r0_rdata", 32'(r0_rdata), 32'(exp_rd[0]));
    chk("r1_rdata", 32'(r1_rdata), 32'(exp_rd[1]));
    chk("be_valid", 32'(be_valid), 32'(m_busy && !m_acc));
    if (m_busy && !m_acc) begin
      chk("be_op",    32'(be_op),    32'(m_op));
      chk("be_addr",  32'(be_addr),  32'(m_addr));
      chk("be_wdata", 32'(be_wdata), 32'(m_wdata));
    end
    chk("ref_pending",  32'(ref_pending),  32'(m_pend));
    chk("ref_overflow", 32'(ref_overflow), 32'(m_ovf));
  endtask

  task automatic cycle();
    gen_inputs();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    check_all();
    if (mode == M_WR) begin
      if (r0_gnt) gcyc = cyc;
      if (r0_done) chk("wr_latency", 32'(cyc - gcyc), 32'd3);
    end
    cyc++;
  endtask

  task automatic run(input int m, input int n);
    mode = m;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int tries;
    preset = 1'b1; r0_req = 1'b1; r1_req = 1'b0; r0_write = 1'b0; r1_write = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    be_ready = 1'b0; be_done = 1'b0; be_rdata = '0;
    m_last = 1; m_pend = 0; m_tcount = 0;
    @(negedge pclk);

    run(M_RST, 3);
    run(M_WR, 40);
    run(M_RR, 40);
    run(M_DEFER, 120);
    run(M_STALL, 100);
    run(M_RAND, 100);
    chk("ovf_sticky", 32'(ref_overflow), 32'd1);
    run(M_RST, 2);
    chk("ovf_cleared", 32'(ref_overflow), 32'd0);
    run(M_COINC, 120);
    run(M_RAND, 400);

    // Reset while a command is waiting for completion.
    tries = 0;
    mode  = M_RAND;
    while (!(m_busy && m_acc) && tries < 200) begin
      cycle();
      tries++;
    end
    if (m_busy && m_acc) begin
      run(M_RST, 1);
      chk("midrst_done",  32'({r1_done, r0_done}), 32'd0);
      chk("midrst_valid", 32'(be_valid), 32'd0);
      chk("midrst_pend",  32'(ref_pending), 32'd0);
      run(M_RAND, 1);
      chk("midrst_done2", 32'({r1_done, r0_done}), 32'd0);
    end else begin
      chk("midrst_reach", 32'd0, 32'd1);
    end

    run(M_RAND, 600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdr_cmd_sched.md
Name: sdr_cmd_sched

Overview:
- Command scheduler in front of the SDR controller core.
- Shares the single SDRAM command path between two requesters (APB host and a second master) and a periodic auto-refresh generator.
- Issues one command at a time over a valid/ready/done handshake to the controller core.
- Returns read data and completion to the originating requester.

Parameters:
- REF_INTERVAL, 780: pclk cycles between refresh ticks.
- REF_MAX_PEND, 4: maximum postponed refreshes before refresh becomes urgent.
- AW, 16: address width.
- DW, 16: data width.

Ports:
- pclk  in  1  clock.
- preset  in  1  synchronous active-high reset.
- r0_req  in  1  requester 0 command request.
- r0_write  in  1  1=write, 0=read.
- r0_addr  in  AW  address.
- r0_wdata  in  DW  write data.
- r0_gnt  out  1  one-cycle grant pulse.
- r0_done  out  1  one-cycle completion pulse.
- r0_rdata  out  DW  read data, valid with r0_done.
- r1_req, r1_write, r1_addr, r1_wdata, r1_gnt, r1_done, r1_rdata: same as r0 for requester 1.
- be_valid  out  1  command valid to controller core.
- be_op  out  2  00 read, 01 write, 10 refresh.
- be_addr  out  AW  latched address (0 for refresh).
- be_wdata  out  DW  latched write data (0 for refresh/read).
- be_ready  in  1  core accepts command.
- be_done  in  1  core finished command.
- be_rdata  in  DW  read data, valid with be_done.
- ref_pending  out  3  postponed refresh count.
- ref_overflow  out  1  sticky: refresh tick lost.

Behaviour:
- Clocking and reset:
  - All state updates on posedge pclk.
  - preset=1 clears: FSM to IDLE, all outputs 0, refresh counter 0, ref_pending 0, ref_overflow 0, round-robin pointer favouring r0.
  - Reset mid-command abandons it; no done pulse is issued.
- Refresh timer:
  - Counter runs 0..REF_INTERVAL-1 and wraps.
  - At wrap, a tick increments ref_pending, saturating at REF_MAX_PEND.
  - A tick while saturated sets ref_overflow, which stays set until reset.
  - Tick and refresh completion in the same cycle leave ref_pending unchanged.
- FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE.
- IDLE arbitration, evaluated each cycle, priority in order:
  1. ref_pending==REF_MAX_PEND: refresh (urgent).
  2. Any rX_req: round-robin between r0 and r1. The requester not most recently granted wins a tie.
  3. ref_pending>0: refresh.
  4. Otherwise stay in IDLE.
- On a decision:
  - Latch op/addr/wdata and the owner ID.
  - Move to ISSUE.
  - In the first ISSUE cycle, pulse the owner's rX_gnt for exactly one cycle (no gnt for refresh).
- Request timing:
  - A requester samples rX_gnt and may change its request fields the next cycle.
  - rX_req still high when IDLE is re-entered is a new request.
- ISSUE:
  - be_valid=1 with stable be_op/addr/wdata until the cycle be_ready=1.
  - Then WAIT_DONE, with be_valid=0 from the next cycle.
- WAIT_DONE:
  - On be_done=1, register be_rdata into the owner's rX_rdata and pulse rX_done the following cycle.
  - For refresh, decrement ref_pending instead.
  - Return to IDLE that same following cycle.
- be_done outside WAIT_DONE is ignored. be_ready outside ISSUE is ignored.
- Latency with no contention: req sampled at edge k; gnt and be_valid high after edge k. With be_ready in that cycle and be_done one cycle later, rX_done is high 3 cycles after gnt.
- rX_rdata holds its last value between completions.
- Back-to-back: one IDLE cycle always separates commands.

Test Plan:
- Reset: hold preset=1 for 3 cycles with r0_req=1 -> no gnt, be_valid=0, ref_pending=0. After release, r0_gnt is pulsed on the first edge.
- Single write: REF_INTERVAL=1000, r0 write addr=0x0123 data=0xBEEF, be_ready tied 1, be_done 1 cycle after accept -> be_op=01, be_addr=0x0123, be_wdata=0xBEEF, r0_done exactly one pulse, r1_gnt never.
- Round-robin: r0_req and r1_req held high continuously -> grants alternate r0, r1, r0, r1 over 4 commands. A read with be_rdata=0x5A5A routes to the correct rX_rdata.
- Refresh deferral: REF_INTERVAL=16, REF_MAX_PEND=4, r0 requesting continuously, r1 idle -> ref_pending reaches 4 by cycle ~64. Next arbitration issues be_op=10 ahead of r0, and ref_pending drops to 3 on completion.
- Overflow: REF_INTERVAL=16, be_ready held 0 for 100 cycles -> ref_pending saturates at 4, ref_overflow=1 and stays 1 after traffic resumes, until preset.
- Simultaneous tick and completion: align refresh be_done with a timer wrap -> ref_pending unchanged.
- Mid-operation reset: assert preset in WAIT_DONE -> no rX_done pulse, FSM in IDLE, counters 0.
